// File: rtl/sram_arb_pkg.sv
// Shared types for the SRAM bus arbiter.
//   arb_state_t : arbiter FSM states
//   arb_gnt_t   : which requester owns the current access
package sram_arb_pkg;

  typedef enum logic [1:0] {ARB_IDLE, ARB_ACCESS, ARB_RESP} arb_state_t;
  typedef enum logic {GNT_IF, GNT_MEM} arb_gnt_t;

endpackage

// File: rtl/sram_bus_arbiter.sv
// sram_bus_arbiter: shares one single-port SRAM between instruction fetch (IF)
// and data access (MEM). One access is in flight at a time; each access holds
// sram_ce for SRAM_LAT cycles and is acknowledged one cycle later.
//
// Ports
//   clk, rst                 clock (rising edge), async active-low reset
//   if_req/if_addr/flush_if  fetch request, address and fetch kill
//   mem_req/we/be/addr/wdata data request
//   if_ack/if_rdata          fetch completion pulse and data
//   mem_ack/mem_rdata        data completion pulse and load data
//   if_stall_req/mem_stall_req  requester stall (req & ~ack)
//   sram_*                   SRAM macro interface
//
// Build option: define SRAM_ARB_RR_EN to resolve IF/MEM ties round-robin;
// otherwise MEM always wins a tie.
//
// state      | meaning
// ARB_IDLE   | no access in flight; arbitrate and latch the winner
// ARB_ACCESS | sram_ce held; count down SRAM_LAT cycles, capture read data
// ARB_RESP   | one-cycle ack to the granted requester
module sram_bus_arbiter
  import sram_arb_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int SRAM_LAT = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  input  logic                flush_if,
  input  logic                mem_req,
  input  logic                mem_we,
  input  logic [DATA_W/8-1:0] mem_be,
  input  logic [ADDR_W-1:0]   mem_addr,
  input  logic [DATA_W-1:0]   mem_wdata,
  output logic                if_ack,
  output logic [DATA_W-1:0]   if_rdata,
  output logic                mem_ack,
  output logic [DATA_W-1:0]   mem_rdata,
  output logic                if_stall_req,
  output logic                mem_stall_req,
  output logic                sram_ce,
  output logic                sram_we,
  output logic [DATA_W/8-1:0] sram_be,
  output logic [ADDR_W-1:0]   sram_addr,
  output logic [DATA_W-1:0]   sram_wdata,
  input  logic [DATA_W-1:0]   sram_rdata
);

  localparam int CNT_W = $clog2(SRAM_LAT + 1);
  localparam int BE_W  = DATA_W / 8;

  arb_state_t         state_q, state_d;
  arb_gnt_t           gnt_q, gnt_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               kill_q, kill_d;
  logic               we_q, we_d;
  logic [BE_W-1:0]    be_q, be_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [DATA_W-1:0]  wdata_q, wdata_d;
  logic [DATA_W-1:0]  rdata_q, rdata_d;

  logic               if_elig;
  logic               grant_vld;
  arb_gnt_t           grant_sel;

`ifdef SRAM_ARB_RR_EN
  arb_gnt_t           last_q, last_d;
`endif

  always_comb begin
    if_elig   = if_req & ~flush_if;
    grant_vld = if_elig | mem_req;
    grant_sel = mem_req ? GNT_MEM : GNT_IF;
`ifdef SRAM_ARB_RR_EN
    // On a tie, hand the bus to whoever did not get it last time.
    if (if_elig && mem_req) begin
      grant_sel = (last_q == GNT_IF) ? GNT_MEM : GNT_IF;
    end
`endif
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    cnt_d   = cnt_q;
    kill_d  = kill_q;
    we_d    = we_q;
    be_d    = be_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
`ifdef SRAM_ARB_RR_EN
    last_d  = last_q;
`endif
    case (state_q)
      ARB_IDLE: begin
        kill_d = 1'b0;
        if (grant_vld) begin
          state_d = ARB_ACCESS;
          gnt_d   = grant_sel;
          cnt_d   = CNT_W'(SRAM_LAT - 1);
          // Fetches never write, so write controls are zeroed for IF.
          if (grant_sel == GNT_MEM) begin
            we_d    = mem_we;
            be_d    = mem_be;
            addr_d  = mem_addr;
            wdata_d = mem_wdata;
          end else begin
            we_d    = 1'b0;
            be_d    = '0;
            addr_d  = if_addr;
            wdata_d = '0;
          end
`ifdef SRAM_ARB_RR_EN
          last_d = grant_sel;
`endif
        end
      end
      ARB_ACCESS: begin
        if (gnt_q == GNT_IF && flush_if) kill_d = 1'b1;
        if (cnt_q == '0) begin
          state_d = ARB_RESP;
          rdata_d = sram_rdata;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ARB_RESP: begin
        state_d = ARB_IDLE;
        kill_d  = 1'b0;
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ARB_IDLE;
      gnt_q   <= GNT_IF;
      cnt_q   <= '0;
      kill_q  <= 1'b0;
      we_q    <= 1'b0;
      be_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
`ifdef SRAM_ARB_RR_EN
      last_q  <= GNT_IF;
`endif
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      cnt_q   <= cnt_d;
      kill_q  <= kill_d;
      we_q    <= we_d;
      be_q    <= be_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
`ifdef SRAM_ARB_RR_EN
      last_q  <= last_d;
`endif
    end
  end

  // A flush arriving in the RESP cycle itself must also swallow the ack,
  // so flush_if is checked live alongside the registered kill flag.
  assign if_ack  = (state_q == ARB_RESP) && (gnt_q == GNT_IF) && !kill_q && !flush_if;
  assign mem_ack = (state_q == ARB_RESP) && (gnt_q == GNT_MEM);

  assign if_rdata  = if_ack ? rdata_q : '0;
  assign mem_rdata = (mem_ack && !we_q) ? rdata_q : '0;

  assign if_stall_req  = if_req & ~if_ack;
  assign mem_stall_req = mem_req & ~mem_ack;

  assign sram_ce    = (state_q == ARB_ACCESS);
  assign sram_we    = sram_ce & we_q;
  assign sram_be    = sram_ce ? be_q : '0;
  assign sram_addr  = sram_ce ? addr_q : '0;
  assign sram_wdata = sram_ce ? wdata_q : '0;

endmodule
